router_fsm_ctrl: RTL
====================

Name: router_fsm_ctrl

Overview:
Controller FSM for the router register/FIFO datapath. Decodes the header address and sequences the header, payload and parity loads into the register block via detect_add, lfd_state, ld_state, laf_state, full_state and rst_int_reg. Handles back-pressure from the destination FIFO and per-port soft reset. Sits between the packet input and router_reg / FIFO write logic; one instance per router.

Parameters:
WAIT_LIMIT, 32, cycles allowed in WAIT_TILL_EMPTY before timeout (used only with ROUTER_FSM_TIMEOUT_EN)
CNT_W, 6, width of timeout counter; must satisfy 2^CNT_W > WAIT_LIMIT

Ports:
clock  input  1  system clock, all state changes on rising edge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  packet byte on data_in is valid
data_in  input  2  header address bits, sampled in DECODE_ADDRESS
fifo_full  input  1  selected destination FIFO full
fifo_empty  input  3  per-port FIFO empty flags, index 0..2
soft_reset  input  3  per-port soft reset pulses, index 0..2
parity_done  input  1  from router_reg: parity byte captured
low_packet_valid  input  1  from router_reg: pkt_valid fell while in LAF path
detect_add  output  1  state == DECODE_ADDRESS
lfd_state  output  1  state == LOAD_FIRST_DATA
ld_state  output  1  state == LOAD_DATA
laf_state  output  1  state == LOAD_AFTER_FULL
full_state  output  1  state == FIFO_FULL_STATE
rst_int_reg  output  1  state == CHECK_PARITY_ERROR
write_enb_reg  output  1  state in {LFD, LD, LP, LAF}
busy  output  1  state in {LFD, FFS, LAF, LP, CPE, WTE}
addr_out  output  2  latched destination address
drop_pkt  output  1  one-cycle pulse on timeout (0 when feature disabled)

Behaviour:
- Clock port clock; reset port resetn, asynchronous, active-low. One clock domain.
- Reset: state=DECODE_ADDRESS, addr_out=0, timeout counter=0, drop_pkt=0. Hence detect_add=1, all other state outputs, write_enb_reg and busy=0.
- All outputs are Moore-decoded from registered state, except addr_out and drop_pkt, which are registered. No combinational input-to-output paths.
- States, 3-bit encoding, and transitions:
  DA (DECODE_ADDRESS): if pkt_valid and data_in!=3: latch addr_out<=data_in; go to LFD if fifo_empty[data_in], else to WTE. data_in==3 or pkt_valid=0 -> stay in DA, byte ignored.
  LFD (LOAD_FIRST_DATA): -> LD unconditionally (1 cycle).
  LD (LOAD_DATA): fifo_full -> FFS; else !pkt_valid -> LP; else stay. fifo_full has priority.
  FFS (FIFO_FULL_STATE): !fifo_full -> LAF; else stay.
  LAF (LOAD_AFTER_FULL): parity_done -> DA; else low_packet_valid -> LP; else -> LD.
  LP (LOAD_PARITY): -> CPE unconditionally.
  CPE (CHECK_PARITY_ERROR): fifo_full -> FFS; else -> DA.
  WTE (WAIT_TILL_EMPTY): fifo_empty[addr_out] -> LFD; else stay.
- Soft reset: soft_reset[addr_out]=1 in any state except DA forces next state DA. It overrides every other transition. soft_reset in DA is ignored, and soft_reset on a non-selected port has no effect.
- Latency: header accepted in DA at edge N; lfd_state=1 in cycle N+1; ld_state=1 from N+2.
- Simultaneous pkt_valid fall and fifo_full in LD -> FFS. Parity is then loaded via the LAF path.
- Unused encodings recover to DA on the next edge.

Optional Feature:
ROUTER_FSM_TIMEOUT_EN
- Defined: the counter clears on WTE entry and increments each cycle in WTE. When it reaches WAIT_LIMIT-1 while the FIFO is still not empty, next state is DA and drop_pkt pulses for 1 cycle. Soft reset still has priority and does not pulse drop_pkt.
- Not defined: no counter is built, WTE waits indefinitely, and drop_pkt is tied to 0.

Test Plan:
- Reset: assert resetn=0 mid-LD -> state goes to DA immediately (async); detect_add=1, ld_state=0, busy=0, addr_out=0.
- Good packet, addr=2, fifo_empty=3'b111, 5 payload bytes, then pkt_valid=0. Expected sequence: DA, LFD(1 cycle), LD for 5 cycles, LP, CPE, DA. write_enb_reg=1 for 7 cycles and rst_int_reg=1 for exactly 1 cycle.
- Back-pressure: fifo_full=1 for 3 cycles during LD -> FFS held 3 cycles, then LAF, then LD (parity_done=0, low_packet_valid=0); full_state=1 for 3 cycles.
- Busy destination: addr=1 with fifo_empty[1]=0 -> WTE, busy=1. Set fifo_empty[1]=1 -> LFD on the next edge.
- Soft reset: soft_reset[2]=1 in LD with addr_out=2 -> DA next edge. Same pulse on soft_reset[0] -> no change.
- Timeout (macro defined, WAIT_LIMIT=4): hold fifo_empty[0]=0 in WTE -> DA after 4 cycles with drop_pkt=1 for 1 cycle. Macro undefined -> stays in WTE and drop_pkt stays 0.

Source files
------------

// File: rtl/router_fsm_ctrl.sv
// Router controller FSM: header decode and header/payload/parity load sequencing.
// Optional WAIT_TILL_EMPTY timeout is built only when ROUTER_FSM_TIMEOUT_EN is defined.
module router_fsm_ctrl #(
    parameter int WAIT_LIMIT = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] soft_reset,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic [1:0] addr_out,
    output logic       drop_pkt
);

    // state | meaning
    // DA    | decode header address
    // LFD   | load first data (header) byte
    // LD    | load payload bytes
    // FFS   | destination FIFO full, hold
    // LAF   | resume load after full
    // LP    | load parity byte
    // CPE   | check parity error
    // WTE   | wait for destination FIFO to drain
    localparam logic [2:0] DA  = 3'd0;
    localparam logic [2:0] LFD = 3'd1;
    localparam logic [2:0] LD  = 3'd2;
    localparam logic [2:0] FFS = 3'd3;
    localparam logic [2:0] LAF = 3'd4;
    localparam logic [2:0] LP  = 3'd5;
    localparam logic [2:0] CPE = 3'd6;
    localparam logic [2:0] WTE = 3'd7;

    if ((2 ** CNT_W) <= WAIT_LIMIT) begin : g_cnt_w_check
        $error("router_fsm_ctrl: CNT_W too narrow for WAIT_LIMIT");
    end

    logic [2:0] state_q, state_d;
    logic [1:0] addr_q, addr_d;

`ifdef ROUTER_FSM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
`ifdef ROUTER_FSM_TIMEOUT_EN
        drop_d  = 1'b0;
        // Counter is zero on the first WTE cycle and counts cycles spent waiting.
        cnt_d   = (state_q == WTE) ? cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            DA: begin
                if (pkt_valid && (data_in != 2'd3)) begin
                    addr_d  = data_in;
                    state_d = fifo_empty[data_in] ? LFD : WTE;
                end
            end
            LFD: state_d = LD;
            LD: begin
                if (fifo_full)       state_d = FFS;
                else if (!pkt_valid) state_d = LP;
            end
            FFS: begin
                if (!fifo_full) state_d = LAF;
            end
            LAF: begin
                if (parity_done)           state_d = DA;
                else if (low_packet_valid) state_d = LP;
                else                       state_d = LD;
            end
            LP:  state_d = CPE;
            CPE: state_d = fifo_full ? FFS : DA;
            WTE: begin
                if (fifo_empty[addr_q]) begin
                    state_d = LFD;
                end
`ifdef ROUTER_FSM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
                    state_d = DA;
                    drop_d  = 1'b1;
                end
`endif
            end
            default: state_d = DA;
        endcase

        // Soft reset of the selected port aborts any in-flight packet, with no drop pulse.
        if ((state_q != DA) && soft_reset[addr_q]) begin
            state_d = DA;
`ifdef ROUTER_FSM_TIMEOUT_EN
            drop_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DA;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

`ifdef ROUTER_FSM_TIMEOUT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    assign drop_pkt = drop_q;
`else
    assign drop_pkt = 1'b0;
`endif

    assign detect_add    = (state_q == DA);
    assign lfd_state     = (state_q == LFD);
    assign ld_state      = (state_q == LD);
    assign laf_state     = (state_q == LAF);
    assign full_state    = (state_q == FFS);
    assign rst_int_reg   = (state_q == CPE);
    assign write_enb_reg = (state_q == LFD) || (state_q == LD) ||
                           (state_q == LP)  || (state_q == LAF);
    assign busy          = (state_q == LFD) || (state_q == FFS) || (state_q == LAF) ||
                           (state_q == LP)  || (state_q == CPE) || (state_q == WTE);
    assign addr_out      = addr_q;

endmodule
